memory_bus_sram8_bridge: RTL and testbench

MEMORY_BUS_SRAM8_BRIDGE -- requirements
Module: memory_bus_sram8_bridge

---
 rtl/memory_bus_sram8_bridge.sv | 138 +++++++++++++
 tb/tb_memory_bus_sram8_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_sram8_bridge.sv
`default_nettype none
// ============================================================================
// memory_bus_sram8_bridge
// 32-bit word bus to 8-bit asynchronous SRAM bridge: four byte accesses per word.
// Revision: 1.0
// ============================================================================
module memory_bus_sram8_bridge #(
  parameter int ADDRESS_SIZE = 15,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [31:0]             dataWrite,
  input  logic                    writeEnable,
  input  logic                    strobe,
  output logic [31:0]             dataRead,
  output logic                    ready,
  output logic [ADDRESS_SIZE+1:0] sramAddr,
  output logic [7:0]              sramDataOut,
  input  logic [7:0]              sramDataIn,
  output logic                    sramDataOe,
  output logic                    sramCe_n,
  output logic                    sramOe_n,
  output logic                    sramWe_n
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  state_t                  state_q;
  logic [1:0]              byte_q;
  logic [1:0]              byte_d;
  logic [3:0]              wait_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic                    we_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    ready_q;
  logic [ADDRESS_SIZE+1:0] sram_addr_q;
  logic [7:0]              sram_dout_q;
  logic                    sram_doe_q;
  logic                    sram_ce_n_q;
  logic                    sram_oe_n_q;
  logic                    sram_we_n_q;

  assign byte_d = byte_q + 2'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      byte_q      <= 2'd0;
      wait_q      <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= 8'd0;
      sram_doe_q  <= 1'b0;
      sram_ce_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      sram_we_n_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe && !ready_q) begin
            addr_q      <= address;
            we_q        <= writeEnable;
            wdata_q     <= dataWrite;
            byte_q      <= 2'd0;
            sram_addr_q <= {address, 2'b00};
            sram_ce_n_q <= 1'b0;
            sram_doe_q  <= writeEnable;
            if (writeEnable) begin
              sram_dout_q <= dataWrite[7:0];
            end
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          wait_q <= c_wait_load;
          if (we_q) begin
            sram_we_n_q <= 1'b0;
          end else begin
            sram_oe_n_q <= 1'b0;
          end
          state_q <= PULSE;
        end
        PULSE: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            sram_we_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            if (!we_q) begin
              rdata_q[{byte_q, 3'b000} +: 8] <= sramDataIn;
            end
            // Address and data move on the same edge the strobe rises, never while it is low.
            if (byte_q != 2'd3) begin
              byte_q      <= byte_d;
              sram_addr_q <= {addr_q, byte_d};
              if (we_q) begin
                sram_dout_q <= wdata_q[{byte_d, 3'b000} +: 8];
              end
              state_q     <= SETUP;
            end else begin
              ready_q     <= 1'b1;
              sram_ce_n_q <= 1'b1;
              sram_doe_q  <= 1'b0;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (!strobe) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataRead    = rdata_q;
  assign ready       = ready_q;
  assign sramAddr    = sram_addr_q;
  assign sramDataOut = sram_dout_q;
  assign sramDataOe  = sram_doe_q;
  assign sramCe_n    = sram_ce_n_q;
  assign sramOe_n    = sram_oe_n_q;
  assign sramWe_n    = sram_we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_sram8_bridge.sv
`default_nettype none
// ============================================================================
// tb_memory_bus_sram8_bridge
// Three bridges (WAIT_CYCLES 0, 1, 3) on shared stimulus, each with its own SRAM.
// Revision: 1.0
// ============================================================================
module tb_memory_bus_sram8_bridge;

  localparam int AW   = 15;
  localparam int NI   = 3;
  localparam int MEMB = 1 << (AW + 2);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   dataWrite = 32'd0;
  logic          writeEnable = 1'b0;
  logic          strobe = 1'b0;

  logic [31:0]   rd  [NI];
  logic          rdy [NI];
  logic [AW+1:0] sa  [NI];
  logic [7:0]    sdo [NI];
  logic [7:0]    sdi [NI];
  logic          soe [NI];
  logic          sce [NI];
  logic          srd [NI];
  logic          swr [NI];

  logic [7:0]    sram [NI][MEMB];

  int n_vec = 0;
  int n_err = 0;

  // monitor state, written only by the monitor process
  int            pulses   [NI];
  int            run      [NI];
  int            clash_cnt  = 0;
  int            move_cnt   = 0;
  int            width_cnt  = 0;
  logic [AW+1:0] prev_a   [NI];
  logic [7:0]    prev_d   [NI];
  logic [AW+1:0] alog     [NI][4];

  // reference model
  logic [31:0]   ref_mem [int];
  int            pool [$];
  logic [31:0]   last_rd = 32'd0;

  always #5 clock = ~clock;

  function automatic int waits(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      memory_bus_sram8_bridge #(
        .ADDRESS_SIZE (AW),
        .WAIT_CYCLES  ((k == 0) ? 0 : (k == 1) ? 1 : 3)
      ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .dataWrite   (dataWrite),
        .writeEnable (writeEnable),
        .strobe      (strobe),
        .dataRead    (rd[k]),
        .ready       (rdy[k]),
        .sramAddr    (sa[k]),
        .sramDataOut (sdo[k]),
        .sramDataIn  (sdi[k]),
        .sramDataOe  (soe[k]),
        .sramCe_n    (sce[k]),
        .sramOe_n    (srd[k]),
        .sramWe_n    (swr[k])
      );
      assign sdi[k] = sram[k][sa[k]];
    end
  endgenerate

  // byte SRAM: a write lands at every clock edge that sees CE and WE both low
  always @(posedge clock) begin
    for (int k = 0; k < NI; k++) begin
      if (!sce[k] && !swr[k]) sram[k][sa[k]] <= sdo[k];
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      pulses[k] = 0;
      run[k]    = 0;
      prev_a[k] = '0;
      prev_d[k] = 8'd0;
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < NI; k++) begin
      if (!srd[k] && soe[k]) clash_cnt++;
      if (!reset) begin
        run[k] = 0;
      end else begin
        if (!swr[k] && ((sa[k] !== prev_a[k]) || (sdo[k] !== prev_d[k]))) move_cnt++;
        if (!swr[k] || !srd[k]) begin
          if (run[k] == 0) begin
            alog[k][pulses[k] % 4] = sa[k];
            pulses[k]++;
          end
          run[k]++;
        end else if (run[k] > 0) begin
          if (run[k] != waits(k) + 1) width_cnt++;
          run[k] = 0;
        end
      end
      prev_a[k] = sa[k];
      prev_d[k] = sdo[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_protocol();
    chk("oe_with_bus_drive", 64'(clash_cnt), 64'd0);
    chk("we_low_addr_move",  64'(move_cnt),  64'd0);
    chk("pulse_width",       64'(width_cnt), 64'd0);
  endtask

  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input int drop_at, input int hold);
    int lat [NI];
    int hi  [NI];
    int n;
    bit done;
    for (int k = 0; k < NI; k++) begin
      lat[k] = -1;
      hi[k]  = 0;
    end
    address = a; dataWrite = d; writeEnable = wr; strobe = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 400) begin
      @(posedge clock); #1; n++;
      if (n == 1) begin
        address     = AW'($urandom);
        dataWrite   = $urandom;
        writeEnable = 1'($urandom_range(0, 1));
      end
      if (drop_at > 0 && n == drop_at) strobe = 1'b0;
      done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (rdy[k]) begin
          if (lat[k] < 0) lat[k] = n - 1;
          hi[k]++;
        end
        if (lat[k] < 0 || (drop_at > 0 && n <= lat[k] + 2)) done = 1'b0;
      end
    end
    chk("txn_completed", 64'(done), 64'd1);
    for (int k = 0; k < NI; k++) chk($sformatf("latency_w%0d", waits(k)), 64'(lat[k]), 64'(4 * (waits(k) + 2)));
    if (drop_at > 0) begin
      for (int k = 0; k < NI; k++) chk("ready_one_cycle", 64'(hi[k]), 64'd1);
    end else begin
      repeat (hold) begin
        @(posedge clock); #1;
        for (int k = 0; k < NI; k++) chk("ready_held", 64'(rdy[k]), 64'd1);
      end
      strobe = 1'b0;
      @(posedge clock); #1;
      for (int k = 0; k < NI; k++) chk("ready_fall", 64'(rdy[k]), 64'd0);
    end
    if (wr) begin
      if (!ref_mem.exists(int'(a))) pool.push_back(int'(a));
      ref_mem[int'(a)] = d;
      for (int k = 0; k < NI; k++)
        for (int b = 0; b < 4; b++)
          chk($sformatf("sram_byte%0d_w%0d", b, waits(k)), 64'(sram[k][{a, 2'(b)}]), 64'(d[8*b +: 8]));
    end else begin
      last_rd = ref_mem[int'(a)];
    end
    for (int k = 0; k < NI; k++) chk($sformatf("data_read_w%0d", waits(k)), 64'(rd[k]), 64'(last_rd));
    chk_protocol();
  endtask

  initial begin
    logic          wr;
    logic [AW-1:0] a;
    logic [AW-1:0] xa;
    int            drop;
    int            base [NI];
    int            n;
    bit            found;

    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", 64'(rdy[k]), 64'd0);
      chk("rst_data_read", 64'(rd[k]), 64'd0);
      chk("rst_strobes", 64'({sce[k], srd[k], swr[k]}), 64'b111);
      chk("rst_bus", 64'({soe[k], sa[k], sdo[k]}), 64'd0);
    end
    reset = 1'b1;

    // word 4 -> bytes 0x10..0x13, then read it back
    run_txn(1'b1, AW'(4), 32'h44332211, 0, 0);
    run_txn(1'b0, AW'(4), $urandom, 0, 0);
    for (int i = 0; i < 4; i++) chk("read_addr_seq", 64'(alog[1][i]), 64'(17'h10 + i));

    // top word, no wrap
    run_txn(1'b1, AW'(15'h7FFF), 32'hDEADBEEF, 0, 0);
    chk("top_byte0", 64'(sram[0][17'h1FFFC]), 64'hEF);
    chk("top_byte3", 64'(sram[0][17'h1FFFF]), 64'hDE);

    // back-to-back with strobe held after ready
    for (int k = 0; k < NI; k++) base[k] = pulses[k];
    run_txn(1'b0, AW'(4), $urandom, 0, 3);
    run_txn(1'b1, AW'(15'h20), $urandom, 0, 0);
    for (int k = 0; k < NI; k++) chk("b2b_access_count", 64'(pulses[k] - base[k]), 64'd8);

    // strobe dropped mid-transaction
    run_txn(1'b1, AW'(15'h23), 32'hA5A5A5A5, 3, 0);

    for (int t = 0; t < 40; t++) begin
      wr = ($urandom_range(0, 1) == 1);
      if (wr) a = AW'($urandom_range(0, 63));
      else    a = AW'(pool[$urandom_range(0, pool.size() - 1)]);
      drop = ($urandom_range(0, 3) == 0) ? 5 : 0;
      run_txn(wr, a, $urandom, drop, $urandom_range(0, 2));
    end

    // reset during the byte-2 write pulse of the WAIT_CYCLES=1 bridge
    xa = AW'(15'h200);
    run_txn(1'b1, xa, 32'h11223344, 0, 0);
    address = xa; dataWrite = 32'hCAFEF00D; writeEnable = 1'b1; strobe = 1'b1;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(posedge clock); #1; n++;
      found = (sa[1][1:0] == 2'd2) && !swr[1];
    end
    chk("reset_window_found", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("async_rst_we_n", 64'(swr[k]), 64'd1);
      chk("async_rst_ce_n", 64'(sce[k]), 64'd1);
      chk("async_rst_doe", 64'(soe[k]), 64'd0);
      chk("async_rst_ready", 64'(rdy[k]), 64'd0);
    end
    strobe = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) chk("rst_hold_ce_n", 64'(sce[k]), 64'd1);
    reset = 1'b1;
    chk("abort_byte0", 64'(sram[1][{xa, 2'd0}]), 64'h0D);
    chk("abort_byte1", 64'(sram[1][{xa, 2'd1}]), 64'hF0);
    chk("abort_byte2", 64'(sram[1][{xa, 2'd2}]), 64'h22);
    chk("abort_byte3", 64'(sram[1][{xa, 2'd3}]), 64'h11);
    last_rd = 32'd0;
    for (int k = 0; k < NI; k++) chk("rst_clears_read", 64'(rd[k]), 64'd0);

    // first transaction straight after reset release
    run_txn(1'b0, AW'(4), $urandom, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
